// File: rtl/gb_mem_pkg.sv
// Shared constants for the Game Boy memory slice: FSM encodings, OAM geometry, echo-RAM fold.
// Includes a page-fold helper shared by bus initiators.
package gb_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;
  localparam logic [1:0] ST_WR    = 2'd3;

  localparam logic [15:0] OAM_BASE   = 16'hFE00;
  localparam int          OAM_LENGTH = 160;

  localparam logic [7:0] ECHO_FOLD_LO     = 8'hE0;
  localparam logic [7:0] ECHO_FOLD_OFFSET = 8'h20;

  // Echo RAM E000..FFFF mirrors C000..DFFF, so those source pages map back down.
  function automatic logic [7:0] fold_page(input logic [7:0] page);
    return (page >= ECHO_FOLD_LO) ? page - ECHO_FOLD_OFFSET : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine behind FF46: copies LENGTH bytes from {page,idx} to OAM, one byte per 2 cycles.
// OAM_DMA_REGREAD_EN enables FF46 readback; otherwise Do_reg reads 8'hFF and rd_reg is ignored.
module oam_dma
  import gb_mem_pkg::*;
#(
  parameter int LENGTH = OAM_LENGTH,
  parameter int IDX_W  = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cs_reg,
  input  logic        wr_reg,
  input  logic        rd_reg,
  input  logic [7:0]  Di_reg,
  output logic [7:0]  Do_reg,
  output logic [15:0] A_src,
  input  logic [7:0]  Di_src,
  output logic        cs_src,
  output logic        rd_src,
  output logic [7:0]  A_oam,
  output logic [7:0]  Do_oam,
  output logic        cs_oam,
  output logic        wr_oam,
  output logic        busy
);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       page_q, page_d;
  logic [15:0]      a_src_q;
  logic [7:0]       a_oam_q;
  logic [7:0]       do_oam_q;
  logic             reg_wr;
  logic             rd_act;
  logic             wr_act;
  logic             last_byte;

`ifdef OAM_DMA_REGREAD_EN
  logic [7:0] raw_q;
  logic [7:0] do_reg_q;

  // A simultaneous read wins and suppresses the write, matching the responders.
  assign reg_wr = cs_reg && wr_reg && !rd_reg;
  assign Do_reg = do_reg_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      raw_q    <= 8'h00;
      do_reg_q <= 8'h00;
    end else begin
      if (reg_wr) raw_q <= Di_reg;
      if (cs_reg && rd_reg) do_reg_q <= raw_q;
    end
  end
`else
  logic unused_rd_reg;

  assign unused_rd_reg = rd_reg;
  assign reg_wr        = cs_reg && wr_reg;
  assign Do_reg        = 8'hFF;
`endif

  assign rd_act    = (state_q == ST_RD);
  assign wr_act    = (state_q == ST_WR);
  assign last_byte = (idx_q == IDX_W'(LENGTH - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_START: begin
        idx_d   = '0;
        state_d = ST_RD;
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        if (last_byte) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A write while busy lets the current RD/WR finish, then restarts from idx 0.
    if (reg_wr) begin
      page_d  = fold_page(Di_reg);
      state_d = ST_START;
    end
  end

  assign cs_src = rd_act;
  assign rd_src = rd_act;
  assign cs_oam = wr_act;
  assign wr_oam = wr_act;
  assign busy   = (state_q != ST_IDLE);

  // Address/data follow the live transfer and hold their last value when inactive.
  assign A_src  = rd_act ? {page_q, 8'(idx_q)} : a_src_q;
  assign A_oam  = wr_act ? 8'(idx_q) : a_oam_q;
  assign Do_oam = wr_act ? Di_src : do_oam_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      page_q   <= 8'h00;
      a_src_q  <= 16'h0000;
      a_oam_q  <= 8'h00;
      do_oam_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      a_src_q  <= A_src;
      a_oam_q  <= A_oam;
      do_oam_q <= Do_oam;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: registered-read source model, OAM capture array, vector table plus corner sequences.
module tb_oam_dma;

  localparam int LEN = 160;
`ifdef OAM_DMA_REGREAD_EN
  localparam logic [7:0] DOREG_RST = 8'h00;
`else
  localparam logic [7:0] DOREG_RST = 8'hFF;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs_reg = 1'b0;
  logic        wr_reg = 1'b0;
  logic        rd_reg = 1'b0;
  logic [7:0]  Di_reg = 8'h00;
  logic [7:0]  Do_reg;
  logic [15:0] A_src;
  logic [7:0]  Di_src;
  logic        cs_src, rd_src;
  logic [7:0]  A_oam, Do_oam;
  logic        cs_oam, wr_oam, busy;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] oam [256];

  typedef struct {
    logic [7:0] wdat;
    logic [7:0] page;
    logic [7:0] rdback;
  } vec_t;

  oam_dma dut (
    .clock(clock), .reset_n(reset_n),
    .cs_reg(cs_reg), .wr_reg(wr_reg), .rd_reg(rd_reg),
    .Di_reg(Di_reg), .Do_reg(Do_reg),
    .A_src(A_src), .Di_src(Di_src), .cs_src(cs_src), .rd_src(rd_src),
    .A_oam(A_oam), .Do_oam(Do_oam), .cs_oam(cs_oam), .wr_oam(wr_oam),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Page C1 holds its own low address byte; other pages are tagged with the page so restarts are visible.
  function automatic logic [7:0] mem_at(input logic [15:0] a);
    if (a[15:8] == 8'hC1) return a[7:0];
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clock) if (cs_src && rd_src) Di_src <= mem_at(A_src);
  always @(posedge clock) if (cs_oam && wr_oam) oam[A_oam] <= Do_oam;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("strobe_excl", {31'd0, rd_src && wr_oam}, 32'd0);
    chk("cs_src_eq_rd", {31'd0, cs_src}, {31'd0, rd_src});
    chk("cs_oam_eq_wr", {31'd0, cs_oam}, {31'd0, wr_oam});
  end

  task automatic reg_write(input logic [7:0] d);
    cs_reg = 1'b1; wr_reg = 1'b1; Di_reg = d;
    @(negedge clock);
    cs_reg = 1'b0; wr_reg = 1'b0;
  endtask

  task automatic reg_read();
    cs_reg = 1'b1; rd_reg = 1'b1;
    @(negedge clock);
    cs_reg = 1'b0; rd_reg = 1'b0;
  endtask

  // Entered at the negedge inside START; walks the whole transfer and checks OAM afterwards.
  task automatic run_body(input logic [7:0] page);
    int busy_cnt;
    int bad;
    busy_cnt = 0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_strobes", {28'd0, cs_src, rd_src, cs_oam, wr_oam}, 32'd0);
    if (busy) busy_cnt++;
    for (int i = 0; i < LEN; i++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      chk("rd_strobe", {29'd0, cs_src, rd_src, wr_oam}, 32'b110);
      chk("rd_addr", {16'd0, A_src}, {16'd0, page, 8'(i)});
      @(negedge clock);
      if (busy) busy_cnt++;
      chk("wr_strobe", {29'd0, cs_oam, wr_oam, rd_src}, 32'b110);
      chk("wr_addr", {24'd0, A_oam}, 32'(i));
      chk("wr_data", {24'd0, Do_oam}, {24'd0, mem_at({page, 8'(i)})});
    end
    @(negedge clock);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("busy_len", busy_cnt, 1 + 2 * LEN);
    chk("a_src_hold", {16'd0, A_src}, {16'd0, page, 8'(LEN - 1)});
    chk("a_oam_hold", {24'd0, A_oam}, 32'(LEN - 1));
    chk("do_oam_hold", {24'd0, Do_oam}, {24'd0, mem_at({page, 8'(LEN - 1)})});
    bad = 0;
    for (int i = 0; i < LEN; i++)
      if (oam[i] !== mem_at({page, 8'(i)})) bad++;
    chk("oam_contents", bad, 0);
  endtask

  initial begin
    vec_t vt[6];
`ifdef OAM_DMA_REGREAD_EN
    vt[0] = '{8'hC1, 8'hC1, 8'hC1};
    vt[1] = '{8'hE3, 8'hC3, 8'hE3};
    vt[2] = '{8'hFF, 8'hDF, 8'hFF};
    vt[3] = '{8'hDF, 8'hDF, 8'hDF};
    vt[4] = '{8'h00, 8'h00, 8'h00};
    vt[5] = '{8'hE0, 8'hC0, 8'hE0};
`else
    vt[0] = '{8'hC1, 8'hC1, 8'hFF};
    vt[1] = '{8'hE3, 8'hC3, 8'hFF};
    vt[2] = '{8'hFF, 8'hDF, 8'hFF};
    vt[3] = '{8'hDF, 8'hDF, 8'hFF};
    vt[4] = '{8'h00, 8'h00, 8'hFF};
    vt[5] = '{8'hE0, 8'hC0, 8'hFF};
`endif

    // Reset held with a register write pending: nothing may start.
    reset_n = 1'b0; cs_reg = 1'b1; wr_reg = 1'b1; Di_reg = 8'hC1;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {28'd0, cs_src, rd_src, cs_oam, wr_oam}, 32'd0);
    chk("rst_do_reg", {24'd0, Do_reg}, {24'd0, DOREG_RST});
    chk("rst_a_src", {16'd0, A_src}, 32'd0);
    chk("rst_a_oam", {24'd0, A_oam}, 32'd0);
    chk("rst_do_oam", {24'd0, Do_oam}, 32'd0);
    reset_n = 1'b1; cs_reg = 1'b0; wr_reg = 1'b0;
    @(negedge clock);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      reg_write(vt[v].wdat);
      run_body(vt[v].page);
      reg_read();
      chk("do_reg_readback", {24'd0, Do_reg}, {24'd0, vt[v].rdback});
    end

    // Simultaneous read+write on FF46.
    cs_reg = 1'b1; rd_reg = 1'b1; wr_reg = 1'b1; Di_reg = 8'hD5;
    @(negedge clock);
    cs_reg = 1'b0; rd_reg = 1'b0; wr_reg = 1'b0;
`ifdef OAM_DMA_REGREAD_EN
    chk("rdwr_no_start", {31'd0, busy}, 32'd0);
    chk("rdwr_do_reg", {24'd0, Do_reg}, 32'hE0);
`else
    run_body(8'hD5);
`endif

    // Restart during byte 50's WR cycle.
    reg_write(8'hC0);
    repeat (101) @(negedge clock);
    chk("rs_rd50_addr", {16'd0, A_src}, 32'hC032);
    @(negedge clock);
    chk("rs_wr50_strobe", {30'd0, wr_oam, rd_src}, 32'b10);
    chk("rs_wr50_addr", {24'd0, A_oam}, 32'h32);
    chk("rs_wr50_data", {24'd0, Do_oam}, {24'd0, mem_at(16'hC032)});
    reg_write(8'hD0);
    chk("rs_oam50", {24'd0, oam[8'h32]}, {24'd0, mem_at(16'hC032)});
    run_body(8'hD0);

    // Synchronous reset during idx=80 RD aborts at once.
    reg_write(8'hC1);
    repeat (161) @(negedge clock);
    chk("mr_rd80_addr", {16'd0, A_src}, 32'hC150);
    chk("mr_rd80_strobe", {31'd0, rd_src}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("mr_strobes", {28'd0, cs_src, rd_src, cs_oam, wr_oam}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_do_reg", {24'd0, Do_reg}, {24'd0, DOREG_RST});
    @(negedge clock);
    chk("mr_stays_idle", {31'd0, busy}, 32'd0);
    reg_write(8'hC1);
    run_body(8'hC1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Bus-initiator counterpart to the registered-read RAM responders (HRAM, WRAM, cartridge RAM): OAM DMA engine behind register FF46.
- A CPU write of the source page starts a burst. The engine issues cs/rd reads on the source bus and cs/wr writes on the OAM bus, one byte per 2 cycles.
- Sits between the CPU register decode, the memory responders (source side) and the OAM RAM (sink side).
- busy drives the CPU bus lockout.

Parameters:
- LENGTH, 160, bytes per transfer (OAM size); valid range 1..256.
- IDX_W, 8, width of the byte index counter.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- cs_reg  in  1  FF46 register select
- wr_reg  in  1  register write strobe
- rd_reg  in  1  register read strobe
- Di_reg  in  8  register write data (source high byte)
- Do_reg  out  8  register read data, registered
- A_src  out  16  source read address
- Di_src  in  8  source read data, valid the cycle after cs_src&&rd_src
- cs_src  out  1  source chip select
- rd_src  out  1  source read strobe
- A_oam  out  8  OAM write address
- Do_oam  out  8  OAM write data
- cs_oam  out  1  OAM chip select
- wr_oam  out  1  OAM write strobe
- busy  out  1  transfer in progress

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, idx=0, src_page=8'h00, Do_reg=8'h00.
  - All strobes 0, A_src=16'h0000, A_oam=8'h00, Do_oam=8'h00, busy=0.
  - Reset mid-transfer aborts immediately; no further strobes are issued.
- Register write (cs_reg&&wr_reg):
  - src_page<=Di_reg.
  - Values 8'hE0..8'hFF fold to Di_reg-8'h20 (echo of C0..DF).
  - Do_reg returns the unfolded written value on cs_reg&&rd_reg, 1-cycle latency.
  - If cs_reg&&rd_reg&&wr_reg are asserted together, the read has priority, as in the responders; no write occurs.
- States: IDLE, START, RD, WR.
  - IDLE: on register write -> START. busy=0.
  - START: one cycle, no strobes. idx<=0. -> RD. busy=1.
  - RD: cs_src=1, rd_src=1, A_src={src_page, idx}. -> WR.
  - WR: cs_oam=1, wr_oam=1, A_oam=idx, Do_oam=Di_src (combinational pass-through of the responder's registered output).
    - If idx==LENGTH-1: -> IDLE, idx<=0.
    - Else: idx<=idx+1, -> RD.
- Strobe rules:
  - Strobes are decoded from state; exactly one of rd_src/wr_oam is high in RD/WR, never both.
  - A_src, A_oam and Do_oam hold their last values outside active states.
- Latency and timing:
  - Register write at edge E -> START during cycle E+1 -> first RD at E+2.
  - Last wr_oam at E+1+2*LENGTH.
  - busy falls the cycle after the last WR; total busy = 1+2*LENGTH cycles (321 for LENGTH=160).
- Restart: a register write while busy (any state except IDLE):
  - updates src_page and re-enters START next cycle.
  - The in-flight RD or WR cycle completes as issued; no partial byte is lost or duplicated at that address.
  - The transfer restarts from idx=0.
- Wrap: idx never exceeds LENGTH-1. With LENGTH=256, idx wraps 8'hFF->8'h00 on exit.

Optional Feature:
- OAM_DMA_REGREAD_EN
  - Defined: Do_reg behaves as above.
  - Undefined: Do_reg is tied to 8'hFF and rd_reg is ignored (write-only register); engine timing is unchanged.

Decomposition:
- Shared package gb_mem_pkg holds:
  - state encoding constants (IDLE/START/RD/WR);
  - OAM_BASE=16'hFE00, OAM_LENGTH=160;
  - ECHO_FOLD_LO=8'hE0, ECHO_FOLD_OFFSET=8'h20.
- No sub-module. The index counter and FSM stay in one module; the responders stay separate.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles while writing FF46=8'hC1 -> busy=0, no strobes, Do_reg=8'h00.
- Basic transfer: preload HRAM-style model at C100..C19F with the low address byte; write 8'hC1 -> 160 RD/WR pairs.
  - A_src=C100+i, A_oam=i, Do_oam=i.
  - busy high exactly 321 cycles.
- Echo fold: write 8'hE3 -> A_src spans C300..C39F; Do_reg reads 8'hE3 (with OAM_DMA_REGREAD_EN).
- Restart: write 8'hC0, then 8'hD0 during byte 50's WR state.
  - Byte 50 is written from C032.
  - Next RD hits D000 after one START cycle.
  - OAM 0..159 finally holds the D0xx data.
- Strobe exclusivity: assert every cycle of a full transfer -> never rd_src&&wr_oam; cs_src==rd_src; cs_oam==wr_oam.
- Reset mid-transfer: deassert reset_n during idx=80 RD -> next cycle all strobes 0, busy=0.
  - A new write of 8'hC1 restarts from idx=0.
